exe_muldiv_unit: RTL and testbench
==================================

// Module: exe_muldiv_unit
// PURPOSE
//  Iterative 32-bit unsigned multiply/divide unit in the EXE stage. Consumes the
//  two operands read from the register file in ID (reg1/reg2 via ID/EXE register).
//  Produces a result plus destination/write-enable for writeback into the register file.
//  Asserts busy so the hazard logic can stall IF/ID/EXE while an operation runs.
// PARAMETERS
//  WIDTH  32  operand/result width; also the number of iteration cycles
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  start      in   1      request new operation; sampled only in IDLE
//  op         in   2      00 MUL (low), 01 MULHU (high), 10 DIVU (quotient), 11 REMU (remainder)
//  src_a      in   WIDTH  multiplicand / dividend
//  src_b      in   WIDTH  multiplier / divisor
//  dest       in   5      destination register index, captured with start
//  flush      in   1      abort in-flight operation (branch taken / exception)
//  busy       out  1      registered; high in RUN and DONE states
//  done       out  1      registered; one-cycle pulse, result valid
//  result     out  WIDTH  selected result; held until the next accepted start
//  dest_out   out  5      captured dest; held with result
//  wb_en      out  1      write enable to register file; equals done
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, busy=0, done=0, wb_en=0, result=0,
//    dest_out=0, count=0, all datapath registers 0.
//  - FSM: IDLE -> RUN on (start & ~flush); RUN -> DONE after WIDTH iterations;
//    DONE -> IDLE unconditionally next edge; any state -> IDLE on flush.
//  - Accept edge E: latch src_a, src_b, op, dest; count=0. RUN performs one
//    iteration per edge E+1..E+WIDTH; edge E+WIDTH enters DONE.
//    done/wb_en high for exactly one cycle, after edge E+WIDTH. busy high from
//    after E through the DONE cycle. Next start accepted no earlier than the cycle
//    after done (the DONE cycle does not accept start).
//  - MUL/MULHU: shift-add on 2*WIDTH accumulator; per iteration: if multiplier
//    LSB then add multiplicand to upper half; shift the accumulator right 1.
//    MUL returns bits [WIDTH-1:0], MULHU bits [2*WIDTH-1:WIDTH].
//  - DIVU/REMU: restoring division; per iteration: shift {rem,quot} left 1,
//    trial subtract divisor from rem (WIDTH+1-bit); if non-negative keep
//    difference and set quot LSB, else restore.
//  - Divide by zero (no special-case logic; falls out of the algorithm):
//    quotient = all ones, remainder = dividend.
//  - result/dest_out update only on the DONE-entering edge; stable otherwise.
//  - start while busy: ignored, no effect on in-flight operation.
//  - flush: next edge -> IDLE, busy=0, no done/wb_en, result retains old value.
//    flush & start in same IDLE cycle: flush wins, start dropped.
//    flush in DONE cycle: done pulse already visible, still completes.
//  - wb_en asserted for dest==0 as well; register-0 policy belongs to the register file.
//  - op latched at accept; changes on op/src_* during RUN have no effect.
// TESTING
//  1 MUL 7*6, dest=5, start at edge E -> done/wb_en high 1 cycle after E+32, result=42, dest_out=5.
//  2 MULHU/MUL 0xFFFFFFFF*0xFFFFFFFF -> MULHU 0xFFFFFFFE, MUL 0x00000001.
//  3 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x80000000/1 -> 0x80000000.
//  4 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; no hang, same 32-cycle latency.
//  5 start pulsed at cycle 10 of a run -> ignored; flush at cycle 12 -> busy=0 next
//    cycle, no done, result unchanged; new MUL 3*4 accepted next -> 12.
//  6 rst raised mid-RUN between clock edges -> busy/done/wb_en/result 0 immediately;
//    after release, MUL 2*3 -> 6 with normal latency.

Source files
------------

// File: rtl/exe_muldiv_unit_if.sv
// Purpose : operand/request and result/writeback bundle between ID/EXE and the mul/div unit.
// Latency : none (wires only).
// Backpres: none here; the requester must hold off while busy is high.
// Ports   : master = ID/EXE side (drives start/op/src_a/src_b/dest/flush),
//           slave  = mul/div unit (drives busy/done/result/dest_out/wb_en).
interface exe_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [4:0]       dest;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       dest_out;
    logic             wb_en;

    modport master (
        output start, op, src_a, src_b, dest, flush,
        input  busy, done, result, dest_out, wb_en
    );

    modport slave (
        input  start, op, src_a, src_b, dest, flush,
        output busy, done, result, dest_out, wb_en
    );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Purpose : iterative unsigned MUL/MULHU/DIVU/REMU unit for the EXE stage.
// Latency : WIDTH iterations after the accept edge; done/wb_en pulse one cycle after that.
// Backpres: busy stays high through RUN and DONE; start is only sampled in IDLE.
// Ports   : clk, rst (async, active-high); bus = exe_muldiv_unit_if.slave carrying
//           start/op/src_a/src_b/dest/flush in and busy/done/result/dest_out/wb_en out.
module exe_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    exe_muldiv_unit_if.slave      bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [1:0]         op_q, op_d;
    // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // MUL: {partial product high, multiplier/product low}; DIV: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [4:0]         dest_q, dest_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         dest_out_q, dest_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // One iteration of either algorithm.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        // The carry out of the add becomes the new MSB after the right shift.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        // Remainder after the left shift, kept WIDTH+1 bits so the shifted-out MSB is not lost.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        trial    = rem_sh - {1'b0, opnd_q};
        acc_step = acc_q;
        if (!op_q[1]) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        dest_d     = dest_q;
        result_d   = result_q;
        dest_out_d = dest_out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d = S_RUN;
                    op_d    = bus.op;
                    dest_d  = bus.dest;
                    count_d = '0;
                    if (bus.op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, bus.src_a};
                        opnd_d = bus.src_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, bus.src_b};
                        opnd_d = bus.src_a;
                    end
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = acc_step;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d    = S_DONE;
                        // Low half holds MUL product low / quotient; high half MULHU / remainder.
                        result_d   = op_q[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
                        dest_out_d = dest_q;
                    end
                end
            end
            // The pulse is already visible, so a flush here changes nothing.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            op_q       <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            dest_q     <= '0;
            result_q   <= '0;
            dest_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            dest_q     <= dest_d;
            result_q   <= result_d;
            dest_out_q <= dest_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wb_en    = done_q;
    assign bus.result   = result_q;
    assign bus.dest_out = dest_out_q;
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Purpose : directed-vector bench for exe_muldiv_unit (table plus multi-cycle corner sequences).
// Latency : expects done exactly 32 edges after the accept edge.
// Backpres: bench never issues start while the unit is busy except to prove it is ignored.
module tb_exe_muldiv_unit;
    localparam int W = 32;
    localparam logic [1:0] OP_MUL = 2'b00, OP_MULHU = 2'b01, OP_DIVU = 2'b10, OP_REMU = 2'b11;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    exe_muldiv_unit_if #(.WIDTH(W)) bus ();
    exe_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // Presents a request for one cycle; returns at the negedge after the accept edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d);
        @(negedge clk);
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.dest  = d;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Polls done on negedges; lat = edges after the accept edge (100 means it never came).
    task automatic wait_done(output int lat);
        bit found;
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done) found = 1'b1;
        end
    endtask

    task automatic do_vec(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp);
        int lat;
        launch(op, a, b, d);
        chk({nm, "_busy_run"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        chk({nm, "_latency"}, 32'(lat), 32'd32);
        chk({nm, "_result"}, bus.result, exp);
        chk({nm, "_dest_out"}, 32'(bus.dest_out), 32'(d));
        chk({nm, "_wb_en"}, 32'(bus.wb_en), 32'd1);
        @(negedge clk);
        chk({nm, "_done_pulse"}, {30'd0, bus.done, bus.wb_en}, 32'd0);
        chk({nm, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_result_hold"}, bus.result, exp);
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [31:0] prev;

        n_cmp  = 0;
        n_fail = 0;

        vecs[0] = '{"mul_7x6",      OP_MUL,   32'd7,          32'd6,          5'd5,  32'd42};
        vecs[1] = '{"mulhu_max",    OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE};
        vecs[2] = '{"mul_max",      OP_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001};
        vecs[3] = '{"divu_100_7",   OP_DIVU,  32'd100,        32'd7,          5'd3,  32'd14};
        vecs[4] = '{"remu_100_7",   OP_REMU,  32'd100,        32'd7,          5'd4,  32'd2};
        vecs[5] = '{"divu_msb_1",   OP_DIVU,  32'h8000_0000,  32'd1,          5'd31, 32'h8000_0000};
        vecs[6] = '{"divu_by_zero", OP_DIVU,  32'd5,          32'd0,          5'd6,  32'hFFFF_FFFF};
        vecs[7] = '{"remu_by_zero", OP_REMU,  32'd5,          32'd0,          5'd7,  32'd5};
        vecs[8] = '{"mul_carry_d0", OP_MUL,   32'h0001_0000,  32'h0001_0000,  5'd0,  32'h0000_0000};
        vecs[9] = '{"mulhu_carry",  OP_MULHU, 32'h0001_0000,  32'h0001_0000,  5'd9,  32'h0000_0001};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.dest  = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done_wb", {30'd0, bus.done, bus.wb_en}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_dest_out", 32'(bus.dest_out), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].exp);
        end

        // Operands and op change during RUN must not affect the latched operation.
        launch(OP_MUL, 32'd9, 32'd9, 5'd12);
        bus.op    = OP_REMU;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        wait_done(lat);
        chk("latched_ops_latency", 32'(lat), 32'd32);
        chk("latched_ops_result", bus.result, 32'd81);

        // The DONE cycle does not accept start.
        bus.op    = OP_MUL;
        bus.src_a = 32'd3;
        bus.src_b = 32'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_cycle_start_busy", 32'(bus.busy), 32'd0);
        chk("done_cycle_start_result", bus.result, 32'd81);

        // start ignored mid-run, then flush aborts without writeback.
        prev = bus.result;
        launch(OP_MUL, 32'd5, 32'd5, 5'd8);
        repeat (9) @(negedge clk);
        bus.op    = OP_DIVU;
        bus.src_a = 32'd77;
        bus.src_b = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_while_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_done", {30'd0, bus.done, bus.wb_en}, 32'd0);
        chk("flush_result_kept", bus.result, prev);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.wb_en || bus.busy) done_seen++;
        end
        chk("flush_no_late_done", 32'(done_seen), 32'd0);
        do_vec("after_flush_mul_3x4", OP_MUL, 32'd3, 32'd4, 5'd10, 32'd12);

        // flush and start together in IDLE: flush wins.
        @(negedge clk);
        bus.op    = OP_MUL;
        bus.src_a = 32'd2;
        bus.src_b = 32'd2;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start_idle_busy", 32'(bus.busy), 32'd0);

        // flush during the DONE cycle: the completion still stands.
        launch(OP_DIVU, 32'd50, 32'd5, 5'd11);
        wait_done(lat);
        chk("flush_done_cycle_lat", 32'(lat), 32'd32);
        chk("flush_done_cycle_wb", 32'(bus.wb_en), 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_done_cycle_busy", 32'(bus.busy), 32'd0);
        chk("flush_done_cycle_result", bus.result, 32'd10);
        chk("flush_done_cycle_dest", 32'(bus.dest_out), 32'd11);

        // Asynchronous reset between clock edges, mid-RUN.
        launch(OP_MUL, 32'd100, 32'd100, 5'd13);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_done_wb", {30'd0, bus.done, bus.wb_en}, 32'd0);
        chk("async_rst_result", bus.result, 32'd0);
        chk("async_rst_dest_out", 32'(bus.dest_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_vec("post_rst_mul_2x3", OP_MUL, 32'd2, 32'd3, 5'd7, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
